// File: rtl/rv64_pkg.sv
// Shared types for the RV64 integer datapath: data width, register address and
// the writeback request carried from execute/memory to the register file.
package rv64_pkg;

    localparam int unsigned XLEN = 64;

    typedef logic [4:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t         rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    typedef enum logic [1:0] {
        SelNone,
        SelLsu,
        SelAlu
    } wb_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests. Full/empty derive only from registered
// pointers, so a same-cycle pop never relieves full.
module wb_fifo
    import rv64_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push_i,
    input  wb_req_t wdata_i,
    input  logic    pop_i,
    output wb_req_t rdata_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;

    ptr_t    wptr_q, wptr_d;
    ptr_t    rptr_q, rptr_d;
    wb_req_t mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            wptr_d = wptr_q + ptr_t'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + ptr_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Write side of the 32x64 register file: arbitrates buffered ALU and unbuffered LSU
// results onto the single rd port and tracks pending writes for RAW stalls.
module regfile_writeback
    import rv64_pkg::*;
#(
    parameter int unsigned ALU_BUF_DEPTH = 2,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  reg_addr_t       alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  reg_addr_t       lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            issue_valid,
    input  reg_addr_t       issue_rd,
    input  reg_addr_t       rs1_addr,
    input  reg_addr_t       rs2_addr,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rd_wen,
    output reg_addr_t       rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            idle
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef logic [SW-1:0] starve_t;

    wb_req_t fifo_head;
    wb_req_t alu_req;
    wb_req_t win_req;
    logic    fifo_full;
    logic    fifo_empty;
    logic    fifo_pop;
    logic    forced;
    wb_sel_e sel;

    starve_t         starve_q, starve_d;
    logic            rd_wen_q, rd_wen_d;
    reg_addr_t       rd_addr_q, rd_addr_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;
    logic [31:0]     busy_q, busy_d;

    assign alu_req.rd   = alu_rd;
    assign alu_req.data = alu_data;

    wb_fifo #(
        .DEPTH (ALU_BUF_DEPTH)
    ) u_alu_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (alu_valid),
        .wdata_i (alu_req),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // The counter only grows while the FIFO holds data, so reaching the limit
    // implies there is a head to force out.
    assign forced    = (starve_q == starve_t'(STARVE_LIMIT)) && !fifo_empty;
    assign alu_ready = !fifo_full;
    assign lsu_ready = !forced;

    always_comb begin
        sel      = SelNone;
        fifo_pop = 1'b0;
        if (forced) begin
            sel      = SelAlu;
            fifo_pop = 1'b1;
        end else if (lsu_valid) begin
            sel = SelLsu;
        end else if (!fifo_empty) begin
            sel      = SelAlu;
            fifo_pop = 1'b1;
        end
    end

    always_comb begin
        win_req = fifo_head;
        if (sel == SelLsu) begin
            win_req.rd   = lsu_rd;
            win_req.data = lsu_data;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (fifo_pop || fifo_empty) begin
            starve_d = '0;
        end else if (sel == SelLsu) begin
            starve_d = starve_q + starve_t'(1);
        end
    end

    // x0 results still consume a slot but never assert the write enable.
    always_comb begin
        rd_wen_d  = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (sel != SelNone) begin
            rd_wen_d  = (win_req.rd != '0);
            rd_addr_d = win_req.rd;
            rd_data_d = win_req.data;
        end
    end

    // Clear first so a same-edge issue to the retiring register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (rd_wen_q) begin
            busy_d[rd_addr_q] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q  <= '0;
            rd_wen_q  <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            busy_q    <= '0;
        end else begin
            starve_q  <= starve_d;
            rd_wen_q  <= rd_wen_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
        end
    end

    assign rs1_busy = busy_q[rs1_addr];
    assign rs2_busy = busy_q[rs2_addr];
    assign rd_wen   = rd_wen_q;
    assign rd_addr  = rd_addr_q;
    assign rd_data  = rd_data_q;
    assign idle     = fifo_empty && !rd_wen_q && (busy_q == '0);

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized bench for regfile_writeback: queue-based reference model compared every
// cycle, plus directed sequences with hand-computed expectations.
module tb_regfile_writeback;
    import rv64_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned LIMIT = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            alu_valid, lsu_valid, issue_valid;
    logic            alu_ready, lsu_ready, rs1_busy, rs2_busy, rd_wen, idle;
    reg_addr_t       alu_rd, lsu_rd, issue_rd, rs1_addr, rs2_addr, rd_addr;
    logic [XLEN-1:0] alu_data, lsu_data, rd_data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    regfile_writeback #(
        .ALU_BUF_DEPTH (DEPTH),
        .STARVE_LIMIT  (LIMIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rd_wen      (rd_wen),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .idle        (idle)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: pending ALU results as a queue, LSU-win streak count,
    // pending-write set, and the write the register file sees this cycle.
    wb_req_t     mq[$];
    int          m_starve = 0;
    bit [31:0]   m_busy = '0;
    bit          m_wen = 1'b0;
    reg_addr_t   m_addr = '0;
    logic [63:0] m_data = '0;
    wb_req_t     m_t, m_in;
    int          m_sz;
    bit          m_took, m_popped, m_lsu_win;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_starve = 0;
            m_busy   = '0;
            m_wen    = 1'b0;
            m_addr   = '0;
            m_data   = '0;
        end else begin
            m_sz      = mq.size();
            m_took    = 1'b0;
            m_popped  = 1'b0;
            m_lsu_win = 1'b0;
            if (m_starve == LIMIT && m_sz > 0) begin
                m_t = mq.pop_front(); m_took = 1'b1; m_popped = 1'b1;
            end else if (lsu_valid) begin
                m_t.rd = lsu_rd; m_t.data = lsu_data; m_took = 1'b1; m_lsu_win = 1'b1;
            end else if (m_sz > 0) begin
                m_t = mq.pop_front(); m_took = 1'b1; m_popped = 1'b1;
            end
            if (alu_valid && m_sz < DEPTH) begin
                m_in.rd = alu_rd; m_in.data = alu_data;
                mq.push_back(m_in);
            end
            if (m_popped || m_sz == 0) m_starve = 0;
            else if (m_lsu_win) m_starve++;
            if (m_wen) m_busy[m_addr] = 1'b0;
            if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
            m_wen = m_took && (m_t.rd != 0);
            if (m_took) begin
                m_addr = m_t.rd;
                m_data = m_t.data;
            end
        end
    end

    always @(negedge clk) begin
        chk("alu_ready", alu_ready, mq.size() < DEPTH);
        chk("lsu_ready", lsu_ready, !(m_starve == LIMIT && mq.size() > 0));
        chk("rs1_busy", rs1_busy, m_busy[rs1_addr]);
        chk("rs2_busy", rs2_busy, m_busy[rs2_addr]);
        chk("rd_wen", rd_wen, m_wen);
        if (m_wen || !rst_n) begin
            chk("rd_addr", rd_addr, m_addr);
            chk("rd_data", rd_data, m_data);
        end
        chk("idle", idle, mq.size() == 0 && !m_wen && m_busy == 0);
    end

    task automatic clr();
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
        issue_valid = 0; issue_rd = '0;
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        rs1_addr = '0;
        rs2_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset idle", idle, 1);
        chk("reset alu_ready", alu_ready, 1);
        chk("reset lsu_ready", lsu_ready, 1);
        chk("reset rd_wen", rd_wen, 0);
        drive_edge();
        rst_n = 1;

        // ALU-only result: two-cycle latency.
        drive_edge();
        alu_valid = 1; alu_rd = 5'd5; alu_data = 64'hDEAD;
        drive_edge();
        clr();
        @(negedge clk);
        chk("t1 wen after push", rd_wen, 0);
        @(negedge clk);
        chk("t1 wen", rd_wen, 1);
        chk("t1 addr", rd_addr, 5);
        chk("t1 data", rd_data, 64'hDEAD);

        // LSU beats ALU in the same cycle.
        drive_edge();
        lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 64'h11;
        alu_valid = 1; alu_rd = 5'd8; alu_data = 64'h22;
        drive_edge();
        clr();
        @(negedge clk);
        chk("t2 first addr", rd_addr, 7);
        chk("t2 first data", rd_data, 64'h11);
        @(negedge clk);
        chk("t2 second addr", rd_addr, 8);
        chk("t2 second wen", rd_wen, 1);

        // Starvation: four LSU wins with x9 waiting, then a forced ALU cycle.
        drive_edge();
        alu_valid = 1; alu_rd = 5'd9; alu_data = 64'h99;
        lsu_valid = 1; lsu_rd = 5'd10; lsu_data = 64'h10;
        for (int i = 0; i < 5; i++) begin
            drive_edge();
            alu_valid = 0;
            lsu_rd    = 5'(11 + i);
            lsu_data  = 64'(11 + i);
            @(negedge clk);
            chk("t3 lsu_ready", lsu_ready, i != 4);
            chk("t3 rd_addr", rd_addr, 10 + i);
        end
        drive_edge();
        clr();
        @(negedge clk);
        chk("t3 forced addr", rd_addr, 9);

        // ALU pushes every cycle while LSU holds the port.
        drive_edge();
        lsu_valid = 1; lsu_rd = 5'd12; alu_valid = 1; alu_rd = 5'd20;
        drive_edge();
        alu_rd = 5'd21;
        drive_edge();
        alu_rd = 5'd22;
        @(negedge clk);
        chk("t4 alu_ready full", alu_ready, 0);
        drive_edge();
        clr();
        repeat (4) drive_edge();

        // Scoreboard: issue and write-back of x3, re-issue on the clearing edge.
        rs1_addr = 5'd3;
        issue_valid = 1; issue_rd = 5'd3;
        alu_valid = 1; alu_rd = 5'd3; alu_data = 64'h33;
        drive_edge();
        clr();
        @(negedge clk);
        chk("t5 busy set", rs1_busy, 1);
        drive_edge();
        issue_valid = 1; issue_rd = 5'd3;
        @(negedge clk);
        chk("t5 wen x3", rd_wen, 1);
        chk("t5 addr x3", rd_addr, 3);
        drive_edge();
        clr();
        @(negedge clk);
        chk("t5 set wins", rs1_busy, 1);
        alu_valid = 0;
        drive_edge();
        alu_valid = 1; alu_rd = 5'd3; alu_data = 64'h34;
        drive_edge();
        clr();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t5 busy cleared", rs1_busy, 0);
        chk("t5 idle", idle, 1);

        // x0 result and reset with a full FIFO.
        drive_edge();
        alu_valid = 1; alu_rd = 5'd0; alu_data = 64'h77;
        drive_edge();
        clr();
        @(negedge clk);
        chk("t6 x0 wen a", rd_wen, 0);
        @(negedge clk);
        chk("t6 x0 wen b", rd_wen, 0);
        drive_edge();
        lsu_valid = 1; lsu_rd = 5'd12; alu_valid = 1; alu_rd = 5'd1; alu_data = 64'h1;
        drive_edge();
        alu_rd = 5'd2; alu_data = 64'h2;
        drive_edge();
        clr();
        @(negedge clk);
        chk("t6 full", alu_ready, 0);
        #1 rst_n = 0;
        #1;
        chk("t6 rst wen", rd_wen, 0);
        chk("t6 rst addr", rd_addr, 0);
        chk("t6 rst data", rd_data, 0);
        chk("t6 rst alu_ready", alu_ready, 1);
        chk("t6 rst idle", idle, 1);
        drive_edge();
        rst_n = 1;

        // Randomized traffic with a mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            drive_edge();
            rst_n       = !(c == 1500);
            alu_valid   = ($urandom_range(0, 99) < 55);
            alu_rd      = 5'($urandom_range(0, 31));
            alu_data    = {$urandom, $urandom};
            lsu_valid   = ($urandom_range(0, 99) < ((c / 200) % 2 == 0 ? 80 : 30));
            lsu_rd      = 5'($urandom_range(0, 31));
            lsu_data    = {$urandom, $urandom};
            issue_valid = ($urandom_range(0, 99) < 30);
            issue_rd    = 5'($urandom_range(0, 31));
            rs1_addr    = 5'($urandom_range(0, 31));
            rs2_addr    = 5'($urandom_range(0, 31));
        end
        drive_edge();
        clr();
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
